// File: rtl/regfile_pkg.sv
// Shared defaults and slicing helper for the scoreboarded register file.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_NUM_RD = 2;
  localparam int DEPTH      = 2 ** DEF_ADDR_W;

  // Low bit of field `idx` in a flattened bus of `width`-bit fields.
  function automatic int unsigned lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_rf_scoreboard.sv
// Busy bits for each register plus the sticky write-to-idle-register flag.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic                 rsv_en,
  input  logic [ADDR_W-1:0]    rsv_addr,
  input  logic                 flush,
  output logic [2**ADDR_W-1:0] busy,
  output logic                 err_wr_idle
);

  localparam int N_REGS = 2 ** ADDR_W;

  logic [N_REGS-1:0] busy_q;
  logic [N_REGS-1:0] busy_d;
  logic              wr_zero;
  logic              err_set;

  assign wr_zero = (ZERO_REG != 0) && (wr_addr == '0);
  assign err_set = wr_en && !busy_q[wr_addr] && !flush && !wr_zero;

  // A reservation beats a same-cycle writeback: the new producer owns the register.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < N_REGS; i++) begin
      if (flush) begin
        busy_d[i] = 1'b0;
      end else if (rsv_en && (rsv_addr == ADDR_W'(i))) begin
        busy_d[i] = 1'b1;
      end else if (wr_en && (wr_addr == ADDR_W'(i))) begin
        busy_d[i] = 1'b0;
      end
    end
    if (ZERO_REG != 0) begin
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= '0;
      err_wr_idle <= 1'b0;
    end else begin
      busy_q <= busy_d;
      if (err_set) begin
        err_wr_idle <= 1'b1;
      end
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with combinational read ports, write-through bypass and busy tracking.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic                     flush,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [2**ADDR_W-1:0]     busy_vec,
  output logic                     err_wr_idle
);

  localparam int N_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [N_REGS];
  logic              wr_zero;
  logic [ADDR_W-1:0] addr_k;

  assign wr_zero = (ZERO_REG != 0) && (wr_addr == '0);

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .rsv_en      (rsv_en),
    .rsv_addr    (rsv_addr),
    .flush       (flush),
    .busy        (busy_vec),
    .err_wr_idle (err_wr_idle)
  );

  // Storage is written regardless of flush; flush only affects busy bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en && !wr_zero) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    addr_k  = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      addr_k = rd_addr[lsb(k, ADDR_W) +: ADDR_W];
      if ((ZERO_REG != 0) && (addr_k == '0)) begin
        rd_data[lsb(k, DATA_W) +: DATA_W] = '0;
        rd_busy[k]                        = 1'b0;
      end else if (wr_en && (wr_addr == addr_k)) begin
        rd_data[lsb(k, DATA_W) +: DATA_W] = wr_data;
        rd_busy[k]                        = 1'b0;
      end else begin
        rd_data[lsb(k, DATA_W) +: DATA_W] = mem[addr_k];
        rd_busy[k]                        = busy_vec[addr_k];
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard (4 read ports, ZERO_REG=1) with an expected-value queue.
module tb_regfile_scoreboard;

  localparam int DW = 32;
  localparam int AW = 3;
  localparam int NR = 4;

  logic           clk;
  logic           rst_n;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [DW-1:0]  wr_data;
  logic           rsv_en;
  logic [AW-1:0]  rsv_addr;
  logic           flush;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]  rd_busy;
  logic [7:0]     busy_vec;
  logic           err_wr_idle;

  logic [DW-1:0] exp_q[$];
  int checks;
  int errors;

  regfile_scoreboard #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .NUM_RD   (NR),
    .ZERO_REG (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rsv_en      (rsv_en),
    .rsv_addr    (rsv_addr),
    .flush       (flush),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .busy_vec    (busy_vec),
    .err_wr_idle (err_wr_idle)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = 1'b0;
    rsv_en = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [AW-1:0] a2, input logic [AW-1:0] a3);
    rd_addr = {a3, a2, a1, a0};
  endtask

  task automatic drive_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
  endtask

  task automatic drive_rsv(input logic [AW-1:0] a);
    rsv_en   = 1'b1;
    rsv_addr = a;
  endtask

  function automatic logic [DW-1:0] port(input int k);
    return rd_data[k*DW +: DW];
  endfunction

  // scoreboard
  task automatic expect_val(input logic [DW-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs);
    logic [DW-1:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s observed=%h expected=<empty queue>", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
    end
  endtask

  initial begin
    logic [DW-1:0] rnd_d;
    logic [AW-1:0] rnd_a;
    checks = 0;
    errors = 0;
    idle();
    wr_addr  = '0;
    wr_data  = '0;
    rsv_addr = '0;
    rst_n    = 1'b0;
    set_rd(3'd0, 3'd7, 3'd0, 3'd7);

    // reset state
    expect_val(32'h0); expect_val(32'h0); expect_val(32'h0);
    expect_val(32'h0); expect_val(32'h0);
    #2;
    check("rst_rd0", port(0));
    check("rst_rd1", port(1));
    check("rst_busy", {28'b0, rd_busy});
    check("rst_busy_vec", {24'b0, busy_vec});
    check("rst_err", {31'b0, err_wr_idle});
    tick();
    rst_n = 1'b1;
    tick();

    // reserve r3, bypassed writeback two cycles later
    set_rd(3'd3, 3'd7, 3'd0, 3'd7);
    drive_rsv(3'd3);
    tick();
    idle();
    expect_val(32'h1); expect_val(32'h08);
    #1;
    check("rsv_rd_busy", {31'b0, rd_busy[0]});
    check("rsv_busy_vec", {24'b0, busy_vec});
    tick();
    drive_wr(3'd3, 32'hDEAD_BEEF);
    expect_val(32'h0); expect_val(32'hDEAD_BEEF);
    #1;
    check("byp_busy", {31'b0, rd_busy[0]});
    check("byp_data", port(0));
    tick();
    idle();
    expect_val(32'h00); expect_val(32'hDEAD_BEEF); expect_val(32'h0);
    #1;
    check("wb_busy_vec", {24'b0, busy_vec});
    check("wb_stored", port(0));
    check("wb_err", {31'b0, err_wr_idle});

    // same-cycle reserve and write to r7: reserve wins
    drive_rsv(3'd7);
    tick();
    drive_wr(3'd7, 32'hACED_CAFE);
    drive_rsv(3'd7);
    tick();
    idle();
    set_rd(3'd0, 3'd7, 3'd0, 3'd7);
    expect_val(32'h80); expect_val(32'hACED_CAFE); expect_val(32'h1); expect_val(32'h0);
    #1;
    check("rsvwr_busy_vec", {24'b0, busy_vec});
    check("rsvwr_data", port(1));
    check("rsvwr_rd_busy", {31'b0, rd_busy[1]});
    check("rsvwr_err", {31'b0, err_wr_idle});

    // register 0 ignores writes and reservations
    drive_wr(3'd0, 32'hFFFF_FFFF);
    drive_rsv(3'd0);
    expect_val(32'h0); expect_val(32'h0);
    #1;
    check("zero_byp_data", port(0));
    check("zero_byp_busy", {31'b0, rd_busy[0]});
    tick();
    idle();
    expect_val(32'h0); expect_val(32'h80); expect_val(32'h0);
    #1;
    check("zero_data", port(0));
    check("zero_busy_vec", {24'b0, busy_vec});
    check("zero_err", {31'b0, err_wr_idle});
    drive_wr(3'd7, 32'h1111_1111);
    tick();
    idle();
    expect_val(32'h00);
    #1;
    check("r7_clear", {24'b0, busy_vec});

    // reserve r1, r2, r5, then flush together with a write to idle r4
    drive_rsv(3'd1); tick();
    drive_rsv(3'd2); tick();
    drive_rsv(3'd5); tick();
    idle();
    expect_val(32'h26);
    #1;
    check("multi_rsv", {24'b0, busy_vec});
    flush = 1'b1;
    drive_wr(3'd4, 32'h4444_0044);
    tick();
    idle();
    set_rd(3'd4, 3'd2, 3'd0, 3'd7);
    expect_val(32'h00); expect_val(32'h0); expect_val(32'h4444_0044);
    #1;
    check("flush_busy_vec", {24'b0, busy_vec});
    check("flush_err", {31'b0, err_wr_idle});
    check("flush_wr_mem", port(0));
    drive_wr(3'd2, 32'h0000_0055);
    tick();
    idle();
    expect_val(32'h1);
    #1;
    check("idle_wr_err", {31'b0, err_wr_idle});
    tick(); tick();
    expect_val(32'h1);
    #1;
    check("err_sticky", {31'b0, err_wr_idle});

    // all four ports on r6 during a write
    set_rd(3'd6, 3'd6, 3'd6, 3'd6);
    drive_wr(3'd6, 32'h1234_5678);
    for (int k = 0; k < NR; k++) expect_val(32'h1234_5678);
    expect_val(32'h0);
    #1;
    for (int k = 0; k < NR; k++) check($sformatf("quad_rd%0d", k), port(k));
    check("quad_busy", {28'b0, rd_busy});
    tick();
    idle();

    // random reserve/writeback pairs on nonzero registers
    for (int n = 0; n < 4; n++) begin
      rnd_a = AW'($urandom_range(1, 7));
      rnd_d = $urandom;
      set_rd(rnd_a, 3'd0, rnd_a, 3'd0);
      drive_rsv(rnd_a);
      tick();
      idle();
      expect_val(32'h5);
      #1;
      check("rnd_rsv_busy", {28'b0, rd_busy});
      drive_wr(rnd_a, rnd_d);
      expect_val(rnd_d); expect_val(rnd_d);
      #1;
      check("rnd_byp0", port(0));
      check("rnd_byp2", port(2));
      tick();
      idle();
    end

    // asynchronous reset with a reservation in flight
    set_rd(3'd6, 3'd3, 3'd7, 3'd2);
    drive_rsv(3'd5);
    #2;
    rst_n = 1'b0;
    expect_val(32'h0); expect_val(32'h0); expect_val(32'h0); expect_val(32'h0);
    #1;
    check("arst_err", {31'b0, err_wr_idle});
    check("arst_busy_vec", {24'b0, busy_vec});
    check("arst_rd0", port(0));
    check("arst_rd1", port(1));
    rst_n = 1'b1;
    idle();
    tick();
    expect_val(32'h00);
    #1;
    check("post_rst_busy_vec", {24'b0, busy_vec});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised, clocked register file with a configurable number of combinational read ports and one synchronous write port. Each register has a busy (scoreboard) bit, so the CPU datapath can reserve a destination at issue and stall dependent reads until writeback. Write-through bypass forwards same-cycle write data to the read ports. It replaces the fixed 8×32, two-read-port register array in the CPU datapath.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers
- NUM_RD, 2, number of read ports (≥1)
- ZERO_REG, 1, if 1, register 0 always reads 0, ignores writes and never goes busy
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rsv_en  in  1  reserve strobe: mark rsv_addr busy
- rsv_addr  in  ADDR_W  register to reserve
- flush  in  1  clear all busy bits (pipeline flush)
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  port k operand not yet available
- busy_vec  out  DEPTH  current busy bits, registered
- err_wr_idle  out  1  sticky: a write hit a non-busy register, registered

## Operation
- Storage: DEPTH × DATA_W flops; busy: DEPTH flops; err_wr_idle: 1 flop.
- Write: on a rising edge with wr_en=1, mem[wr_addr] <= wr_data. Ignored for address 0 when ZERO_REG=1.
- Busy update per register i, applied in priority order:
  - flush=1 → busy[i]<=0.
  - else rsv_en=1 and rsv_addr==i → busy[i]<=1. This takes priority over a same-address write: a new producer replaces the old one.
  - else wr_en=1 and wr_addr==i → busy[i]<=0.
  - else hold.
- Read port k, combinational:
  - ZERO_REG=1 and addr==0 → data 0, busy 0.
  - wr_en=1 and wr_addr==addr → data=wr_data (bypass), busy 0.
  - else data=mem[addr], busy=busy[addr].
- Any number of read ports may use the same address; all of them return identical results.
- err_wr_idle is set on a rising edge where wr_en=1, busy[wr_addr]=0, flush=0 and the target is not a ZERO_REG address 0. Only reset clears it.
- A write with flush=1 still updates mem.

## Timing
- Read latency: 0 cycles (combinational from rd_addr, wr_*, internal state).
- Write latency: 1 cycle to storage; 0 cycles to readers via bypass.
- Reserve: busy visible on busy_vec and rd_busy the cycle after rsv_en.
- Reset, asynchronous on rst_n fall: all mem = 0, busy_vec = 0, err_wr_idle = 0. With wr_en=0 during reset, rd_data = 0 and rd_busy = 0.
- Reset deasserted mid-operation: the first rising edge after release behaves normally. A reservation in flight before reset is lost.
- Address wrap: none. All ADDR_W codes are valid registers.

## Structure
- Shared package regfile_pkg:
  - default DATA_W, ADDR_W, NUM_RD
  - localparam DEPTH = 2**ADDR_W
  - helper function for slicing flattened ports
- Optional sub-module rf_scoreboard (busy bits and err_wr_idle, parametrised on ADDR_W). The storage array and read muxing stay in the top module.

## Test plan
- Reset with rd_addr={3'd7,3'd0} → rd_data=0, rd_busy=0, busy_vec=0, err_wr_idle=0.
- Reserve r3 at cycle 0; write 32'hDEAD_BEEF to r3 at cycle 2 while reading r3:
  - cycle 1: rd_busy=1
  - cycle 2: rd_busy=0, rd_data=DEAD_BEEF via bypass
  - cycle 3: busy_vec[3]=0
- Reserve r7; write 32'hACED_CAFE to r7 with rsv_en=1, rsv_addr=7 in the same cycle → mem[7]=ACED_CAFE, busy_vec[7] stays 1.
- ZERO_REG=1: write 32'hFFFF_FFFF to r0 and reserve r0 → rd_data=0, rd_busy=0, err_wr_idle unchanged.
- Reserve r1, r2, r5; assert flush → busy_vec=0 next cycle. A later write to r2 sets err_wr_idle=1, which stays set until rst_n=0.
- NUM_RD=4, all ports reading r6 during a write of 32'h1234_5678 to r6 → all four ports return 1234_5678 in the same cycle.
